// File: rtl/pipeline_ctrl.sv
// Pipeline control: debug run/step/halt sequencing,
// hazard stalls/flushes, halt drain and advance-cycle counting.
module pipeline_ctrl #(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 i_rst,
    input  logic                 i_start,
    input  logic                 i_step,
    input  logic                 i_halt_req,
    input  logic                 i_halt_instr,
    input  logic                 i_load_use,
    input  logic                 i_branch_taken,
    output logic                 o_pc_en,
    output logic                 o_if_id_en,
    output logic                 o_id_ex_en,
    output logic                 o_ex_mem_en,
    output logic                 o_mem_wb_en,
    output logic                 o_if_id_flush,
    output logic                 o_id_ex_flush,
    output logic [2:0]           o_state,
    output logic                 o_done,
    output logic [CNT_WIDTH-1:0] o_cycle_cnt
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RUN   = 3'd1,
        STEP  = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE =
        {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    state_t               state;
    state_t               state_nx;
    logic [1:0]           drain_cnt;
    logic [1:0]           drain_nx;
    logic [CNT_WIDTH-1:0] cnt;

    logic                 adv_pc_en;
    logic                 adv_if_id_en;
    logic                 adv_if_id_flush;
    logic                 adv_id_ex_flush;
    logic                 adv_halt;

    // Advance-cycle enables; a taken branch squashes both hazards and halt.
    always_comb begin
        adv_pc_en       = 1'b1;
        adv_if_id_en    = 1'b1;
        adv_if_id_flush = 1'b0;
        adv_id_ex_flush = 1'b0;
        adv_halt        = 1'b0;
        if (i_branch_taken) begin
            adv_if_id_flush = 1'b1;
            adv_id_ex_flush = 1'b1;
        end else if (i_halt_instr) begin
            adv_pc_en       = 1'b0;
            adv_if_id_en    = 1'b0;
            adv_id_ex_flush = 1'b1;
            adv_halt        = 1'b1;
        end else if (i_load_use) begin
            adv_pc_en       = 1'b0;
            adv_if_id_en    = 1'b0;
            adv_id_ex_flush = 1'b1;
        end
    end

    // Next-state and per-state enable/flush outputs.
    always_comb begin
        state_nx      = state;
        drain_nx      = 2'd0;
        o_pc_en       = 1'b0;
        o_if_id_en    = 1'b0;
        o_id_ex_en    = 1'b0;
        o_ex_mem_en   = 1'b0;
        o_mem_wb_en   = 1'b0;
        o_if_id_flush = 1'b0;
        o_id_ex_flush = 1'b0;
        o_done        = 1'b0;
        case (state)
            IDLE: begin
                if (i_start) begin
                    state_nx = RUN;
                end else if (i_step) begin
                    state_nx = STEP;
                end
            end
            RUN, STEP: begin
                if (state == RUN && i_halt_req) begin
                    state_nx = IDLE;
                end else begin
                    o_pc_en       = adv_pc_en;
                    o_if_id_en    = adv_if_id_en;
                    o_id_ex_en    = 1'b1;
                    o_ex_mem_en   = 1'b1;
                    o_mem_wb_en   = 1'b1;
                    o_if_id_flush = adv_if_id_flush;
                    o_id_ex_flush = adv_id_ex_flush;
                    if (adv_halt) begin
                        state_nx = DRAIN;
                    end else if (state == STEP) begin
                        state_nx = IDLE;
                    end
                end
            end
            DRAIN: begin
                o_id_ex_en    = 1'b1;
                o_id_ex_flush = 1'b1;
                o_ex_mem_en   = 1'b1;
                o_mem_wb_en   = 1'b1;
                if (drain_cnt == 2'd2) begin
                    state_nx = DONE;
                end else begin
                    drain_nx = drain_cnt + 2'd1;
                end
            end
            DONE: begin
                o_done = 1'b1;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // State and drain counter registers.
    always_ff @(posedge clk) begin
        if (i_rst) begin
            state     <= IDLE;
            drain_cnt <= 2'd0;
        end else begin
            state     <= state_nx;
            drain_cnt <= drain_nx;
        end
    end

    // Saturating count of cycles in which MEM/WB advances.
    always_ff @(posedge clk) begin
        if (i_rst) begin
            cnt <= '0;
        end else if (o_mem_wb_en && cnt != '1) begin
            cnt <= cnt + CNT_ONE;
        end
    end

    assign o_state     = state;
    assign o_cycle_cnt = cnt;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: directed vectors
// push expected outputs, a negedge monitor pops and compares.
module tb_pipeline_ctrl;

    logic        clk = 1'b0;
    logic        rst, start, stp, hreq, hins, lu, br;
    logic        pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
    logic        if_id_fl, id_ex_fl, done;
    logic [2:0]  st;
    logic [31:0] cnt;
    logic        pc4, ifid4, idex4, exmem4, memwb4, iff4, idf4, done4;
    logic [2:0]  st4;
    logic [3:0]  cnt4;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pipeline_ctrl #(.CNT_WIDTH(32)) dut (
        .clk(clk), .i_rst(rst), .i_start(start), .i_step(stp),
        .i_halt_req(hreq), .i_halt_instr(hins), .i_load_use(lu),
        .i_branch_taken(br),
        .o_pc_en(pc_en), .o_if_id_en(if_id_en), .o_id_ex_en(id_ex_en),
        .o_ex_mem_en(ex_mem_en), .o_mem_wb_en(mem_wb_en),
        .o_if_id_flush(if_id_fl), .o_id_ex_flush(id_ex_fl),
        .o_state(st), .o_done(done), .o_cycle_cnt(cnt)
    );

    pipeline_ctrl #(.CNT_WIDTH(4)) dut4 (
        .clk(clk), .i_rst(rst), .i_start(start), .i_step(stp),
        .i_halt_req(hreq), .i_halt_instr(hins), .i_load_use(lu),
        .i_branch_taken(br),
        .o_pc_en(pc4), .o_if_id_en(ifid4), .o_id_ex_en(idex4),
        .o_ex_mem_en(exmem4), .o_mem_wb_en(memwb4),
        .o_if_id_flush(iff4), .o_id_ex_flush(idf4),
        .o_state(st4), .o_done(done4), .o_cycle_cnt(cnt4)
    );

    typedef struct {
        string       nm;
        logic [2:0]  st;
        logic [4:0]  en;
        logic [1:0]  fl;
        logic        dn;
        logic [31:0] cnt;
        logic [3:0]  cnt4;
    } exp_t;

    exp_t sb[$];

    localparam logic [6:0] N   = 7'b0000000;
    localparam logic [6:0] RST = 7'b1000000;
    localparam logic [6:0] STA = 7'b0100000;
    localparam logic [6:0] STP = 7'b0010000;
    localparam logic [6:0] HRQ = 7'b0001000;
    localparam logic [6:0] HIN = 7'b0000100;
    localparam logic [6:0] LU  = 7'b0000010;
    localparam logic [6:0] BR  = 7'b0000001;

    localparam logic [4:0] ALL = 5'b11111;
    localparam logic [4:0] STL = 5'b00111;
    localparam logic [4:0] OFF = 5'b00000;

    task automatic drive(input logic [6:0] in);
        @(posedge clk);
        #1;
        {rst, start, stp, hreq, hins, lu, br} = in;
    endtask

    task automatic v(input string nm, input logic [6:0] in,
                     input logic [2:0] est, input logic [4:0] een,
                     input logic [1:0] efl, input logic edn,
                     input int ecnt);
        exp_t e;
        drive(in);
        e.nm   = nm;
        e.st   = est;
        e.en   = een;
        e.fl   = efl;
        e.dn   = edn;
        e.cnt  = ecnt;
        e.cnt4 = (ecnt > 15) ? 4'd15 : ecnt[3:0];
        sb.push_back(e);
    endtask

    // Compare the presented outputs against the oldest expectation.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            logic [4:0] aen;
            logic [1:0] afl;
            e   = sb.pop_front();
            aen = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en};
            afl = {if_id_fl, id_ex_fl};
            checks++;
            if (st !== e.st || aen !== e.en || afl !== e.fl ||
                done !== e.dn || cnt !== e.cnt || cnt4 !== e.cnt4) begin
                failures++;
                $display("FAIL %s got st=%0d en=%b fl=%b dn=%b cnt=%0d cnt4=%0d exp st=%0d en=%b fl=%b dn=%b cnt=%0d cnt4=%0d",
                         e.nm, st, aen, afl, done, cnt, cnt4,
                         e.st, e.en, e.fl, e.dn, e.cnt, e.cnt4);
            end
        end
    end

    initial begin
        {rst, start, stp, hreq, hins, lu, br} = RST;
        drive(RST);
        drive(RST);

        v("reset",      N,   0, OFF, 2'b00, 0, 0);
        v("idle_start", STA, 0, OFF, 2'b00, 0, 0);
        for (int i = 0; i < 10; i++)
            v("run", N, 1, ALL, 2'b00, 0, i);
        v("load_use",   LU,      1, STL, 2'b01, 0, 10);
        v("lu_branch",  LU | BR, 1, ALL, 2'b11, 0, 11);
        v("run_plain",  N,       1, ALL, 2'b00, 0, 12);
        v("halt_br",    HIN | BR, 1, ALL, 2'b11, 0, 13);
        v("halt_instr", HIN,     1, STL, 2'b01, 0, 14);
        v("drain0",     HRQ,     3, STL, 2'b01, 0, 15);
        v("drain1",     STA | LU, 3, STL, 2'b01, 0, 16);
        v("drain2",     BR | STP, 3, STL, 2'b01, 0, 17);
        v("done",       N,       4, OFF, 2'b00, 1, 18);
        v("done_start", STA,     4, OFF, 2'b00, 1, 18);
        v("done_step",  STP,     4, OFF, 2'b00, 1, 18);
        v("done_rst",   RST,     4, OFF, 2'b00, 1, 18);
        v("post_rst",   N,       0, OFF, 2'b00, 0, 0);

        v("step1_cmd",  STP,       0, OFF, 2'b00, 0, 0);
        v("step1",      HRQ,       2, ALL, 2'b00, 0, 0);
        v("step1_idle", N,         0, OFF, 2'b00, 0, 1);
        v("step2_cmd",  STP,       0, OFF, 2'b00, 0, 1);
        v("step2",      N,         2, ALL, 2'b00, 0, 1);
        v("step2_idle", N,         0, OFF, 2'b00, 0, 2);
        v("step3_cmd",  STP,       0, OFF, 2'b00, 0, 2);
        v("step3_lu",   LU,        2, STL, 2'b01, 0, 2);
        v("step3_idle", N,         0, OFF, 2'b00, 0, 3);

        v("start_wins", STA | STP, 0, OFF, 2'b00, 0, 3);
        v("halt_req",   HRQ | HIN, 1, OFF, 2'b00, 0, 3);
        v("halt_idle",  N,         0, OFF, 2'b00, 0, 3);

        v("rd_start",   STA,       0, OFF, 2'b00, 0, 3);
        v("rd_halt",    HIN,       1, STL, 2'b01, 0, 3);
        v("rd_drain0",  N,         3, STL, 2'b01, 0, 4);
        v("rd_drain1",  RST,       3, STL, 2'b01, 0, 5);
        v("rd_post",    N,         0, OFF, 2'b00, 0, 0);

        v("sh_cmd",     STP,       0, OFF, 2'b00, 0, 0);
        v("sh_step",    HIN,       2, STL, 2'b01, 0, 0);
        v("sh_drain0",  N,         3, STL, 2'b01, 0, 1);
        v("sh_drain1",  N,         3, STL, 2'b01, 0, 2);
        v("sh_drain2",  N,         3, STL, 2'b01, 0, 3);
        v("sh_done",    N,         4, OFF, 2'b00, 1, 4);
        v("sh_rst",     RST,       4, OFF, 2'b00, 1, 4);

        v("sat_start",  STA,       0, OFF, 2'b00, 0, 0);
        for (int i = 0; i < 20; i++)
            v("sat_run", N, 1, ALL, 2'b00, 0, i);
        v("sat_end",    RST,       1, ALL, 2'b00, 0, 20);
        v("sat_post",   N,         0, OFF, 2'b00, 0, 0);

        repeat (3) @(posedge clk);
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain_queue got %0d pending exp 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
